// File: rtl/sha256_job_sequencer.sv
// Job sequencer for a SHA-256 round pipeline: loads midstate and message words,
// issues one pipeline pass, adds the midstate back in and streams the digest out.
module sha256_job_sequencer #(
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [255:0] pipe_rx_state,
    output logic [511:0] pipe_w_in,
    output logic         pipe_start,
    input  logic [255:0] pipe_tx_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last
);

    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_e;

    state_e       state_q, state_d;
    logic [4:0]   wordCnt_q, wordCnt_d;
    logic [7:0]   latCnt_q, latCnt_d;
    logic [255:0] rxState_q, rxState_d;
    logic [511:0] wIn_q, wIn_d;
    logic [255:0] digest_q, digest_d;
    logic [2:0]   idx_q, idx_d;
    logic [31:0]  outData_q, outData_d;
    logic         outLast_q, outLast_d;

    logic         accept;
    logic         handshake;
    logic [3:0]   msgIdx;
    logic [2:0]   idxInc;

    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;
    assign msgIdx    = 4'(wordCnt_q - 5'd8);
    assign idxInc    = idx_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            wordCnt_q <= 5'd0;
            latCnt_q  <= 8'd0;
            rxState_q <= '0;
            wIn_q     <= '0;
            digest_q  <= '0;
            idx_q     <= 3'd0;
            outData_q <= 32'd0;
            outLast_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wordCnt_q <= wordCnt_d;
            latCnt_q  <= latCnt_d;
            rxState_q <= rxState_d;
            wIn_q     <= wIn_d;
            digest_q  <= digest_d;
            idx_q     <= idx_d;
            outData_q <= outData_d;
            outLast_q <= outLast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept && wordCnt_q == 5'd23) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (latCnt_q == 8'd0) state_d = DRAIN;
            DRAIN:   if (handshake && idx_q == 3'd7) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        wordCnt_d = wordCnt_q;
        latCnt_d  = latCnt_q;
        rxState_d = rxState_q;
        wIn_d     = wIn_q;
        digest_d  = digest_q;
        idx_d     = idx_q;
        outData_d = outData_q;
        outLast_d = outLast_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (wordCnt_q < 5'd8) rxState_d[{wordCnt_q[2:0], 5'd0} +: 32] = in_data;
                    else                  wIn_d[{msgIdx, 5'd0} +: 32] = in_data;
                    wordCnt_d = (wordCnt_q == 5'd23) ? 5'd0 : wordCnt_q + 5'd1;
                end
            end
            ISSUE: latCnt_d = 8'(LATENCY - 1);
            WAIT: begin
                if (latCnt_q == 8'd0) begin
                    // Feed-forward add is per word; carries never cross word boundaries.
                    for (int i = 0; i < 8; i++)
                        digest_d[32*i +: 32] = rxState_q[32*i +: 32] + pipe_tx_state[32*i +: 32];
                    outData_d = rxState_q[31:0] + pipe_tx_state[31:0];
                    outLast_d = 1'b0;
                    idx_d     = 3'd0;
                end else begin
                    latCnt_d = latCnt_q - 8'd1;
                end
            end
            DRAIN: begin
                if (handshake) begin
                    idx_d     = idxInc;
                    outData_d = digest_q[{idxInc, 5'd0} +: 32];
                    outLast_d = (idxInc == 3'd7);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == LOAD);
        pipe_start = (state_q == ISSUE);
        out_valid  = (state_q == DRAIN);
    end

    assign pipe_rx_state = rxState_q;
    assign pipe_w_in     = wIn_q;
    assign out_data      = outData_q;
    assign out_last      = outLast_q;

endmodule

// File: tb/tb_sha256_job_sequencer.sv
// Directed bench for sha256_job_sequencer: three instances (LATENCY 2, 1, 64), each
// driven by a register-chain pipeline stub whose output tap can be moved.
module tb_sha256_job_sequencer;

    localparam int NDUT = 3;

    logic         clk;
    logic         rst_n;
    logic         inValid   [NDUT];
    logic [31:0]  inData    [NDUT];
    logic         inReady   [NDUT];
    logic [255:0] rxState   [NDUT];
    logic [511:0] wIn       [NDUT];
    logic         pipeStart [NDUT];
    logic [255:0] txState   [NDUT];
    logic         outValid  [NDUT];
    logic         outReady  [NDUT];
    logic [31:0]  outData   [NDUT];
    logic         outLast   [NDUT];

    logic [255:0] chain     [NDUT][65];
    logic [255:0] stubConst [NDUT];
    logic [255:0] stubIdle  [NDUT];
    int           tap       [NDUT];
    int           startCount[NDUT];
    int           startSnap [NDUT];
    int           compared;
    int           mismatched;

    logic [255:0] midA, midB, midWrap, expA, expB, expWrap, expDelayed, stubOnes, stubWrap, stubIdleVal;
    logic [511:0] msgA, msgB;
    int           cycles;

    sha256_job_sequencer #(.LATENCY(2)) dutL2 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
        .pipe_rx_state(rxState[0]), .pipe_w_in(wIn[0]), .pipe_start(pipeStart[0]),
        .pipe_tx_state(txState[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .out_data(outData[0]), .out_last(outLast[0])
    );

    sha256_job_sequencer #(.LATENCY(1)) dutL1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .pipe_rx_state(rxState[1]), .pipe_w_in(wIn[1]), .pipe_start(pipeStart[1]),
        .pipe_tx_state(txState[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .out_data(outData[1]), .out_last(outLast[1])
    );

    sha256_job_sequencer #(.LATENCY(64)) dutL64 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
        .pipe_rx_state(rxState[2]), .pipe_w_in(wIn[2]), .pipe_start(pipeStart[2]),
        .pipe_tx_state(txState[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
        .out_data(outData[2]), .out_last(outLast[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pipeline stub: the start cycle injects the programmed constant, every other cycle the idle value.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            chain[d][0] <= pipeStart[d] ? stubConst[d] : stubIdle[d];
            for (int k = 1; k < 65; k++) chain[d][k] <= chain[d][k-1];
        end
    end

    assign txState[0] = chain[0][tap[0]];
    assign txState[1] = chain[1][tap[1]];
    assign txState[2] = chain[2][tap[2]];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < NDUT; d++) begin
            if (!rst_n)            startCount[d] <= 0;
            else if (pipeStart[d]) startCount[d] <= startCount[d] + 1;
        end
    end

    function automatic int latOf(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 64;
        endcase
    endfunction

    task automatic compare(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; leaves in the issue cycle T.
    task automatic applyStimulus(input int d, input logic [255:0] mid, input logic [511:0] msg,
                                 input bit gaps, output int nCycles);
        int  w     = 0;
        int  guard = 0;
        bit  acc;
        startSnap[d] = startCount[d];
        while (w < 24 && guard < 3000) begin
            inValid[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            inData[d]  = (w < 8) ? mid[32*w +: 32] : msg[32*(w-8) +: 32];
            acc = inValid[d] && inReady[d];
            @(negedge clk);
            if (acc) w++;
            guard++;
        end
        inValid[d] = 1'b0;
        nCycles = guard;
        compare("load_complete", 512'(w), 512'(24));
        compare("issue_start", 512'(pipeStart[d]), 512'(1));
        compare("issue_in_ready", 512'(inReady[d]), 512'(0));
        compare("issue_rx_state", 512'(rxState[d]), 512'(mid));
        compare("issue_w_in", wIn[d], msg);
    endtask

    task automatic waitDigest(input int d);
        int n = 0;
        while (!outValid[d] && n < 400) begin
            @(negedge clk);
            n++;
        end
        compare("capture_latency", 512'(n), 512'(latOf(d) + 1));
        compare("start_pulses", 512'(startCount[d] - startSnap[d]), 512'(1));
    endtask

    task automatic checkOutput(input int d, input logic [255:0] exp, input int stall, input int nWords);
        for (int k = 0; k < nWords; k++) begin
            outReady[d] = 1'b0;
            for (int s = 0; s < stall; s++) begin
                compare("stall_valid", 512'(outValid[d]), 512'(1));
                compare("stall_data", 512'(outData[d]), 512'(exp[32*k +: 32]));
                @(negedge clk);
            end
            outReady[d] = 1'b1;
            compare("digest_valid", 512'(outValid[d]), 512'(1));
            compare("digest_data", 512'(outData[d]), 512'(exp[32*k +: 32]));
            compare("digest_last", 512'(outLast[d]), 512'(k == 7));
            @(negedge clk);
        end
        outReady[d] = 1'b0;
        if (nWords == 8) begin
            compare("post_drain_valid", 512'(outValid[d]), 512'(0));
            compare("post_drain_in_ready", 512'(inReady[d]), 512'(1));
        end
    endtask

    task automatic pulseReset(input int d);
        rst_n = 1'b0;
        #1;
        compare("rst_out_valid", 512'(outValid[d]), 512'(0));
        compare("rst_out_data", 512'(outData[d]), 512'(0));
        compare("rst_out_last", 512'(outLast[d]), 512'(0));
        compare("rst_pipe_start", 512'(pipeStart[d]), 512'(0));
        compare("rst_rx_state", 512'(rxState[d]), 512'(0));
        compare("rst_w_in", wIn[d], 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            compare("rst_in_ready", 512'(inReady[d]), 512'(1));
            compare("rst_no_digest", 512'(outValid[d]), 512'(0));
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            midA[32*i +: 32]        = 32'h1000_0000 + 32'(i);
            midB[32*i +: 32]        = 32'h2000_0000 + 32'(i);
            expA[32*i +: 32]        = 32'h1000_0001 + 32'(i);
            expB[32*i +: 32]        = 32'h2000_0001 + 32'(i);
            expDelayed[32*i +: 32]  = 32'h1000_0100 + 32'(i);
            stubOnes[32*i +: 32]    = 32'h0000_0001;
            stubIdleVal[32*i +: 32] = 32'h0000_0100;
        end
        for (int i = 0; i < 16; i++) begin
            msgA[32*i +: 32] = 32'(i);
            msgB[32*i +: 32] = 32'h0000_00A0 + 32'(i);
        end
        midWrap             = midA;
        midWrap[96 +: 32]   = 32'hFFFF_FFFF;
        stubWrap            = stubOnes;
        stubWrap[96 +: 32]  = 32'h0000_0002;
        expWrap             = expA;
        expWrap[96 +: 32]   = 32'h0000_0001;
        for (int d = 0; d < NDUT; d++) begin
            inValid[d]   = 1'b0;
            inData[d]    = 32'd0;
            outReady[d]  = 1'b0;
            stubConst[d] = stubOnes;
            stubIdle[d]  = stubIdleVal;
            tap[d]       = latOf(d) - 1;
        end

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compare("reset_out_valid", 512'(outValid[0]), 512'(0));
        compare("reset_out_data", 512'(outData[0]), 512'(0));
        compare("reset_out_last", 512'(outLast[0]), 512'(0));
        compare("reset_pipe_start", 512'(pipeStart[0]), 512'(0));
        compare("reset_rx_state", 512'(rxState[0]), 512'(0));
        compare("reset_w_in", wIn[0], 512'(0));
        rst_n = 1'b1;
        @(negedge clk);
        compare("reset_in_ready", 512'(inReady[0]), 512'(1));

        $display("[TB] basic job, LATENCY=2");
        applyStimulus(0, midA, msgA, 1'b0, cycles);
        compare("basic_load_cycles", 512'(cycles), 512'(24));
        waitDigest(0);
        checkOutput(0, expA, 0, 8);

        $display("[TB] per-word wrap-around");
        stubConst[0] = stubWrap;
        applyStimulus(0, midWrap, msgA, 1'b0, cycles);
        waitDigest(0);
        checkOutput(0, expWrap, 0, 8);
        stubConst[0] = stubOnes;

        $display("[TB] input gaps and output backpressure");
        applyStimulus(0, midA, msgA, 1'b1, cycles);
        waitDigest(0);
        checkOutput(0, expA, 5, 8);

        $display("[TB] reset during WAIT");
        applyStimulus(0, midA, msgA, 1'b0, cycles);
        @(negedge clk);
        pulseReset(0);

        $display("[TB] reset during DRAIN word 4");
        applyStimulus(0, midA, msgA, 1'b0, cycles);
        waitDigest(0);
        checkOutput(0, expA, 0, 4);
        compare("drain4_data", 512'(outData[0]), 512'(32'h1000_0005));
        pulseReset(0);

        $display("[TB] full job after reset");
        applyStimulus(0, midA, msgA, 1'b0, cycles);
        waitDigest(0);
        checkOutput(0, expA, 0, 8);

        $display("[TB] back-to-back jobs");
        applyStimulus(0, midA, msgA, 1'b0, cycles);
        inValid[0] = 1'b1;
        inData[0]  = midB[31:0];
        waitDigest(0);
        checkOutput(0, expA, 0, 8);
        applyStimulus(0, midB, msgB, 1'b0, cycles);
        compare("b2b_second_load_cycles", 512'(cycles), 512'(24));
        waitDigest(0);
        checkOutput(0, expB, 0, 8);

        $display("[TB] LATENCY=1 exact and delayed stub");
        applyStimulus(1, midA, msgA, 1'b0, cycles);
        waitDigest(1);
        checkOutput(1, expA, 0, 8);
        tap[1] = latOf(1);
        applyStimulus(1, midA, msgA, 1'b0, cycles);
        waitDigest(1);
        checkOutput(1, expDelayed, 0, 8);

        $display("[TB] LATENCY=64 exact and delayed stub");
        applyStimulus(2, midA, msgA, 1'b0, cycles);
        waitDigest(2);
        checkOutput(2, expA, 0, 8);
        tap[2] = latOf(2);
        applyStimulus(2, midA, msgA, 1'b0, cycles);
        waitDigest(2);
        checkOutput(2, expDelayed, 0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
